median_result_writer: RTL and testbench

- Downstream stage of the median filter core: accepts the four filtered pixels and the write address the core produces each output cycle.
- Packs them into one 32-bit word and buffers it in a small FIFO.
- Drives the write port of the output dual_port_ram through a valid/ready handshake.
- Counts words committed per frame and raises end_of_operation when the frame is complete.

---
 rtl/median_result_writer.sv | 121 ++++++++++++
 tb/tb_median_result_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/median_result_writer.sv
// median_result_writer: packs median-core pixels into words, buffers them and writes them to the output RAM
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   start               one-cycle pulse arming a new frame (ignored while running)
//   in_valid/in_ready   input handshake for pixel1..pixel4 and waddr
//   pixel1..pixel4      filtered pixels, pixel1 in the lowest byte of the word
//   waddr               output word address, carried alongside the data
//   mem_w_ena/ready     write handshake towards the output RAM
//   mem_w_addr/data     registered write address and packed word
//   words_written       words committed in the current frame
//   end_of_operation    sticky frame-complete flag
//   overflow            sticky flag: input offered while not ready during a frame
module median_result_writer #(
    parameter int PIXEL_DATA_WIDTH = 8,
    parameter int MEM_DATA_WIDTH   = 32,
    parameter int MEM_ADDR_WIDTH   = 14,
    parameter int FIFO_DEPTH       = 4,
    parameter int FRAME_WORDS      = 12800
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PIXEL_DATA_WIDTH-1:0] pixel1,
    input  logic [PIXEL_DATA_WIDTH-1:0] pixel2,
    input  logic [PIXEL_DATA_WIDTH-1:0] pixel3,
    input  logic [PIXEL_DATA_WIDTH-1:0] pixel4,
    input  logic [MEM_ADDR_WIDTH-1:0]   waddr,
    output logic                        mem_w_ena,
    input  logic                        mem_w_ready,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_w_addr,
    output logic [MEM_DATA_WIDTH-1:0]   mem_w_data,
    output logic [14:0]                 words_written,
    output logic                        end_of_operation,
    output logic                        overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = MEM_ADDR_WIDTH + MEM_DATA_WIDTH;
    localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
    localparam logic [14:0] FRAME = 15'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_n;
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_count;
    logic [14:0]   accepted;
    logic          push, pop, w_fire, arm;

    // in_ready depends only on registered state, so a pop in the same cycle never frees a slot early
    assign in_ready = (state == RUN) && (fifo_count < DEPTH) && (accepted < FRAME);
    assign push     = in_valid & in_ready;
    assign w_fire   = mem_w_ena & mem_w_ready;
    // the output slice reloads whenever it is empty or its word is leaving this cycle
    assign pop      = (fifo_count != '0) && (!mem_w_ena || mem_w_ready);
    assign arm      = start && (state != RUN);

    always_comb begin
        state_n = state;
        if (state == RUN)
            state_n = (w_fire && words_written == FRAME - 15'd1) ? DONE : RUN;
        else if (start)
            state_n = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepted         <= '0;
            words_written    <= '0;
            end_of_operation <= 1'b0;
            overflow         <= 1'b0;
        end else if (arm) begin
            accepted         <= '0;
            words_written    <= '0;
            end_of_operation <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            if (push) accepted <= accepted + 15'd1;
            if (w_fire && state == RUN) words_written <= words_written + 15'd1;
            if (state == RUN && in_valid && !in_ready) overflow <= 1'b1;
            if (state == RUN && state_n == DONE) end_of_operation <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {waddr, pixel4, pixel3, pixel2, pixel1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_w_ena  <= 1'b0;
            mem_w_addr <= '0;
            mem_w_data <= '0;
        end else if (pop) begin
            mem_w_ena                <= 1'b1;
            {mem_w_addr, mem_w_data} <= fifo_mem[rd_ptr];
        end else if (w_fire) begin
            mem_w_ena <= 1'b0;
        end
    end
endmodule

// File: tb/tb_median_result_writer.sv
// tb_median_result_writer: directed self-checking bench for median_result_writer
module tb_median_result_writer;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready;
    logic [7:0]  pixel1, pixel2, pixel3, pixel4;
    logic [13:0] waddr;
    logic        mem_w_ena, mem_w_ready;
    logic [13:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic [14:0] words_written;
    logic        end_of_operation, overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_acc = 0;
    logic [45:0] wq [$];
    int          wcyc [$];

    median_result_writer #(
        .PIXEL_DATA_WIDTH(8), .MEM_DATA_WIDTH(32), .MEM_ADDR_WIDTH(14),
        .FIFO_DEPTH(4), .FRAME_WORDS(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3), .pixel4(pixel4), .waddr(waddr),
        .mem_w_ena(mem_w_ena), .mem_w_ready(mem_w_ready), .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data), .words_written(words_written),
        .end_of_operation(end_of_operation), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // inputs change just after a rising edge, so the falling edge sees what the next rising edge will
    always @(negedge clk) begin
        if (mem_w_ena && mem_w_ready) begin
            wq.push_back({mem_w_addr, mem_w_data});
            wcyc.push_back(cyc);
        end
        if (in_valid && in_ready) n_acc++;
    end

    function automatic logic [45:0] word(input int i);
        logic [7:0] b;
        b = 8'(4 * i + 1);
        return {14'(i), b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_w_ready = 1'b0;
        {waddr, pixel4, pixel3, pixel2, pixel1} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_words(input int base, input int cnt);
        logic acc;
        int t;
        for (int k = 0; k < cnt; k++) begin
            {waddr, pixel4, pixel3, pixel2, pixel1} = word(base + k);
            in_valid = 1'b1; acc = 1'b0; t = 0;
            while (!acc && t < 20) begin
                acc = in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: word %0d not accepted within 20 cycles", base + k);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_w_ready = 1'b0;
        {waddr, pixel4, pixel3, pixel2, pixel1} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({in_ready, mem_w_ena, end_of_operation, overflow} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {in_ready, mem_w_ena, end_of_operation, overflow}); end
        n_cmp++; if (mem_w_addr !== 14'd0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", mem_w_addr); end
        n_cmp++; if (mem_w_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", mem_w_data); end
        n_cmp++; if (words_written !== 15'd0) begin n_bad++; $display("FAIL reset_words: got %0d expected 0", words_written); end
    endtask

    task automatic test_basic();
        do_reset();
        wq.delete(); wcyc.delete();
        mem_w_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            {waddr, pixel4, pixel3, pixel2, pixel1} = word(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 0) begin
                n_cmp++; if (mem_w_ena !== 1'b0) begin n_bad++; $display("FAIL basic_latency_early: mem_w_ena got %b expected 0", mem_w_ena); end
            end
            if (i == 1) begin
                n_cmp++; if (mem_w_ena !== 1'b1) begin n_bad++; $display("FAIL basic_latency: mem_w_ena got %b expected 1", mem_w_ena); end
                n_cmp++; if (mem_w_data !== 32'h04030201) begin n_bad++; $display("FAIL basic_data: got %h expected 04030201", mem_w_data); end
                n_cmp++; if (mem_w_addr !== 14'd0) begin n_bad++; $display("FAIL basic_addr: got %h expected 0", mem_w_addr); end
            end
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (words_written !== 15'd4) begin n_bad++; $display("FAIL basic_words: got %0d expected 4", words_written); end
        n_cmp++; if (wq.size() !== 4) begin n_bad++; $display("FAIL basic_count: got %0d writes expected 4", wq.size()); end
        if (wq.size() == 4) begin
            n_cmp++; if (wcyc[3] - wcyc[0] !== 3) begin n_bad++; $display("FAIL basic_consecutive: span %0d expected 3", wcyc[3] - wcyc[0]); end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (wq[i] !== word(i)) begin n_bad++; $display("FAIL basic_word%0d: got %h expected %h", i, wq[i], word(i)); end
            end
        end
    endtask

    task automatic test_frame_end();
        do_reset();
        mem_w_ready = 1'b1;
        pulse_start();
        send_words(0, 8);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL frame_ready_after_last: got %b expected 0", in_ready); end
        {waddr, pixel4, pixel3, pixel2, pixel1} = word(8);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL frame_overflow: got %b expected 1", overflow); end
        n_cmp++; if ({end_of_operation, words_written} !== {1'b0, 15'd7}) begin n_bad++; $display("FAIL frame_before_last: eoo/words got %b/%0d expected 0/7", end_of_operation, words_written); end
        @(posedge clk); #1;
        n_cmp++; if ({end_of_operation, words_written} !== {1'b1, 15'd8}) begin n_bad++; $display("FAIL frame_done: eoo/words got %b/%0d expected 1/8", end_of_operation, words_written); end
    endtask

    task automatic test_restart();
        wq.delete();
        pulse_start();
        n_cmp++; if ({end_of_operation, overflow, in_ready, words_written} !== {3'b001, 15'd0}) begin n_bad++; $display("FAIL restart_clear: eoo/ovf/rdy/words got %b/%b/%b/%0d expected 0/0/1/0", end_of_operation, overflow, in_ready, words_written); end
        send_words(0, 4);
        pulse_start();
        send_words(4, 4);
        repeat (6) @(posedge clk); #1;
        n_cmp++; if ({end_of_operation, words_written} !== {1'b1, 15'd8}) begin n_bad++; $display("FAIL restart_done: eoo/words got %b/%0d expected 1/8", end_of_operation, words_written); end
        n_cmp++; if (wq.size() !== 8) begin n_bad++; $display("FAIL restart_count: got %0d writes expected 8", wq.size()); end
        if (wq.size() == 8) begin
            n_cmp++; if (wq[7] !== word(7)) begin n_bad++; $display("FAIL restart_last: got %h expected %h", wq[7], word(7)); end
        end
    endtask

    task automatic test_stall();
        int n;
        logic acc, have, bad;
        logic [45:0] cap;
        do_reset();
        pulse_start();
        wq.delete();
        n = 0; have = 1'b0; bad = 1'b0; cap = '0;
        for (int c = 0; c < 10; c++) begin
            {waddr, pixel4, pixel3, pixel2, pixel1} = word(40 + n);
            in_valid = 1'b1;
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) n++;
            if (mem_w_ena) begin
                if (!have) begin cap = {mem_w_addr, mem_w_data}; have = 1'b1; end
                else if ({mem_w_addr, mem_w_data} !== cap) bad = 1'b1;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL stall_accepted: got %0d expected 5", n); end
        n_cmp++; if ({in_ready, mem_w_ena} !== 2'b01) begin n_bad++; $display("FAIL stall_flags: rdy/ena got %b expected 01", {in_ready, mem_w_ena}); end
        n_cmp++; if ({have, bad} !== 2'b10) begin n_bad++; $display("FAIL stall_stable: have/changed got %b expected 10", {have, bad}); end
        n_cmp++; if (cap !== word(40)) begin n_bad++; $display("FAIL stall_head: got %h expected %h", cap, word(40)); end
    endtask

    task automatic test_full_pop();
        int a0;
        {waddr, pixel4, pixel3, pixel2, pixel1} = word(45);
        in_valid = 1'b1; mem_w_ready = 1'b1;
        a0 = n_acc;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_blocked: in_ready got %b expected 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (n_acc !== a0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL full_after_pop: accepts %0d rdy %b expected %0d/1", n_acc, in_ready, a0); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (n_acc !== a0 + 1) begin n_bad++; $display("FAIL full_next_accept: got %0d expected %0d", n_acc, a0 + 1); end
        repeat (8) @(posedge clk); #1;
        n_cmp++; if (wq.size() !== 6 || mem_w_ena !== 1'b0) begin n_bad++; $display("FAIL drain_count: got %0d writes ena %b expected 6/0", wq.size(), mem_w_ena); end
        if (wq.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (wq[i] !== word(40 + i)) begin n_bad++; $display("FAIL drain_word%0d: got %h expected %h", i, wq[i], word(40 + i)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        send_words(20, 3);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({in_ready, mem_w_ena, end_of_operation, overflow} !== 4'b0) begin n_bad++; $display("FAIL midreset_flags: got %b expected 0000", {in_ready, mem_w_ena, end_of_operation, overflow}); end
        n_cmp++; if ({mem_w_addr, mem_w_data, words_written} !== 61'd0) begin n_bad++; $display("FAIL midreset_values: addr %h data %h words %0d expected 0", mem_w_addr, mem_w_data, words_written); end
        @(posedge clk); #1 rst = 1'b0;
        wq.delete();
        mem_w_ready = 1'b1;
        pulse_start();
        send_words(30, 1);
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (wq.size() !== 1) begin n_bad++; $display("FAIL midreset_count: got %0d writes expected 1", wq.size()); end
        if (wq.size() > 0) begin
            n_cmp++; if (wq[0] !== word(30)) begin n_bad++; $display("FAIL midreset_fresh: got %h expected %h", wq[0], word(30)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_end();
        test_restart();
        test_stall();
        test_full_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
